// File: rtl/baccarat_pkg.sv
// Shared definitions for the Baccarat card/score datapath:
// card codes, active-low 7-segment patterns (gfedcba) and scoring helpers.
package baccarat_pkg;

    localparam logic [3:0] CARD_NONE  = 4'd0;
    localparam logic [3:0] CARD_ACE   = 4'd1;
    localparam logic [3:0] CARD_TWO   = 4'd2;
    localparam logic [3:0] CARD_THREE = 4'd3;
    localparam logic [3:0] CARD_FOUR  = 4'd4;
    localparam logic [3:0] CARD_FIVE  = 4'd5;
    localparam logic [3:0] CARD_SIX   = 4'd6;
    localparam logic [3:0] CARD_SEVEN = 4'd7;
    localparam logic [3:0] CARD_EIGHT = 4'd8;
    localparam logic [3:0] CARD_NINE  = 4'd9;
    localparam logic [3:0] CARD_TEN   = 4'd10;
    localparam logic [3:0] CARD_JACK  = 4'd11;
    localparam logic [3:0] CARD_QUEEN = 4'd12;
    localparam logic [3:0] CARD_KING  = 4'd13;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ACE   = 7'b0001000;
    localparam logic [6:0] SEG_TWO   = 7'b0100100;
    localparam logic [6:0] SEG_THREE = 7'b0110000;
    localparam logic [6:0] SEG_FOUR  = 7'b0011001;
    localparam logic [6:0] SEG_FIVE  = 7'b0010010;
    localparam logic [6:0] SEG_SIX   = 7'b0000010;
    localparam logic [6:0] SEG_SEVEN = 7'b1111000;
    localparam logic [6:0] SEG_EIGHT = 7'b0000000;
    localparam logic [6:0] SEG_NINE  = 7'b0010000;
    localparam logic [6:0] SEG_TEN   = 7'b1000000;
    localparam logic [6:0] SEG_JACK  = 7'b1100001;
    localparam logic [6:0] SEG_QUEEN = 7'b0011000;
    localparam logic [6:0] SEG_KING  = 7'b0001001;

    // Baccarat point value: pips count face value, no-card/ten/faces count zero.
    function automatic logic [3:0] card_value(input logic [3:0] card);
        if (card >= CARD_ACE && card <= CARD_NINE)
            return card;
        else
            return 4'd0;
    endfunction

    // Reduce a three-card sum (0..27) to its last decimal digit.
    function automatic logic [3:0] mod10(input logic [4:0] sum);
        if (sum >= 5'd20)
            return 4'(sum - 5'd20);
        else if (sum >= 5'd10)
            return 4'(sum - 5'd10);
        else
            return 4'(sum);
    endfunction

endpackage

// File: rtl/card7seg.sv
// Card code to active-low 7-segment decoder (bit order gfedcba).
// Unused codes and "no card" show a blank digit.
module card7seg
    import baccarat_pkg::*;
(
    input  logic [3:0] card_i,
    output logic [6:0] seg_o
);

    // Pure lookup from card code to segment pattern.
    always_comb begin
        seg_o = SEG_BLANK;
        case (card_i)
            CARD_ACE:   seg_o = SEG_ACE;
            CARD_TWO:   seg_o = SEG_TWO;
            CARD_THREE: seg_o = SEG_THREE;
            CARD_FOUR:  seg_o = SEG_FOUR;
            CARD_FIVE:  seg_o = SEG_FIVE;
            CARD_SIX:   seg_o = SEG_SIX;
            CARD_SEVEN: seg_o = SEG_SEVEN;
            CARD_EIGHT: seg_o = SEG_EIGHT;
            CARD_NINE:  seg_o = SEG_NINE;
            CARD_TEN:   seg_o = SEG_TEN;
            CARD_JACK:  seg_o = SEG_JACK;
            CARD_QUEEN: seg_o = SEG_QUEEN;
            CARD_KING:  seg_o = SEG_KING;
            default:    seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/datapath.sv
// Baccarat card/score datapath: free-running 1..13 card generator, six card
// registers loaded by one-hot strobes, mod-10 hand scores and six digit decoders.
// Optional macro FAST_ENTROPY_EN: the synchronized fast_clock level makes the
// card generator skip one value on that edge, adding run-to-run randomness.
module datapath
    import baccarat_pkg::*;
(
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic       fast_clock,
    input  logic       load_pcard1,
    input  logic       load_pcard2,
    input  logic       load_pcard3,
    input  logic       load_dcard1,
    input  logic       load_dcard2,
    input  logic       load_dcard3,
    output logic [3:0] pcard3_out,
    output logic [3:0] pscore_out,
    output logic [3:0] dscore_out,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5
);

    // Index order: 0..2 player cards 1..3, 3..5 dealer cards 1..3.
    logic [5:0] load_vec;
    logic [3:0] card_q [6];
    logic [3:0] card_d [6];
    logic [6:0] seg    [6];
    logic [3:0] new_card_q;
    logic [3:0] new_card_d;

    assign load_vec = {load_dcard3, load_dcard2, load_dcard1,
                       load_pcard3, load_pcard2, load_pcard1};

`ifdef FAST_ENTROPY_EN
    logic [1:0] fast_sync_q;

    // Two-flop synchronizer bringing the fast toggle into the slow domain.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb)
            fast_sync_q <= 2'b00;
        else
            fast_sync_q <= {fast_sync_q[0], fast_clock};
    end
`else
    // Deterministic build: the fast toggle is deliberately left unconnected.
    logic fast_clock_unused;
    assign fast_clock_unused = fast_clock;
`endif

    // Next card: step by one (or two with entropy), wrapping within 1..13.
    always_comb begin
        new_card_d = (new_card_q == CARD_KING) ? CARD_ACE : new_card_q + 4'd1;
`ifdef FAST_ENTROPY_EN
        if (fast_sync_q[1]) begin
            if (new_card_q == CARD_QUEEN)
                new_card_d = CARD_ACE;
            else if (new_card_q == CARD_KING)
                new_card_d = CARD_TWO;
            else
                new_card_d = new_card_q + 4'd2;
        end
`endif
    end

    // Card generator register; restarts at Ace on reset.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb)
            new_card_q <= CARD_ACE;
        else
            new_card_q <= new_card_d;
    end

    // Each strobed register captures the current card; simultaneous loads share it.
    always_comb begin
        for (int i = 0; i < 6; i++)
            card_d[i] = load_vec[i] ? new_card_q : card_q[i];
    end

    // Card registers, cleared only by reset.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < 6; i++)
                card_q[i] <= CARD_NONE;
        end else begin
            for (int i = 0; i < 6; i++)
                card_q[i] <= card_d[i];
        end
    end

    for (genvar gi = 0; gi < 6; gi++) begin : g_seg
        card7seg u_card7seg (
            .card_i (card_q[gi]),
            .seg_o  (seg[gi])
        );
    end

    // Hand scores: 5-bit sums (max 27) reduced to a single digit.
    always_comb begin
        pscore_out = mod10({1'b0, card_value(card_q[0])} +
                           {1'b0, card_value(card_q[1])} +
                           {1'b0, card_value(card_q[2])});
        dscore_out = mod10({1'b0, card_value(card_q[3])} +
                           {1'b0, card_value(card_q[4])} +
                           {1'b0, card_value(card_q[5])});
    end

    assign pcard3_out = card_q[2];
    assign HEX0 = seg[0];
    assign HEX1 = seg[1];
    assign HEX2 = seg[2];
    assign HEX3 = seg[3];
    assign HEX4 = seg[4];
    assign HEX5 = seg[5];

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath (default build, FAST_ENTROPY_EN undefined).
// Reference model: the card generator is the edge count since reset mod 13
// plus one; cards and scores are plain integers; segments come from a table.
module tb_datapath;

    logic       slow_clock = 1'b0;
    logic       resetb     = 1'b0;
    logic       fast_clock = 1'b0;
    logic [5:0] ld         = 6'b0;
    logic [3:0] pcard3_out, pscore_out, dscore_out;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    int errors = 0;
    int checks = 0;

    // Model state
    int         edges_since_reset;
    int         m_card [6];
    logic [6:0] seg_tab [16];

    datapath dut (
        .slow_clock  (slow_clock),
        .resetb      (resetb),
        .fast_clock  (fast_clock),
        .load_pcard1 (ld[0]),
        .load_pcard2 (ld[1]),
        .load_pcard3 (ld[2]),
        .load_dcard1 (ld[3]),
        .load_dcard2 (ld[4]),
        .load_dcard3 (ld[5]),
        .pcard3_out  (pcard3_out),
        .pscore_out  (pscore_out),
        .dscore_out  (dscore_out),
        .HEX0        (HEX0),
        .HEX1        (HEX1),
        .HEX2        (HEX2),
        .HEX3        (HEX3),
        .HEX4        (HEX4),
        .HEX5        (HEX5)
    );

    always #5 slow_clock = ~slow_clock;
    always #3 fast_clock = ~fast_clock;

    function automatic int pts(input int c);
        return (c >= 1 && c <= 9) ? c : 0;
    endfunction

    function automatic int current_card();
        return (edges_since_reset % 13) + 1;
    endfunction

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [3:0] ps, ds, p3;
        ps = 4'((pts(m_card[0]) + pts(m_card[1]) + pts(m_card[2])) % 10);
        ds = 4'((pts(m_card[3]) + pts(m_card[4]) + pts(m_card[5])) % 10);
        p3 = 4'(m_card[2]);
        chk({tag, ".HEX0"}, HEX0, seg_tab[m_card[0]]);
        chk({tag, ".HEX1"}, HEX1, seg_tab[m_card[1]]);
        chk({tag, ".HEX2"}, HEX2, seg_tab[m_card[2]]);
        chk({tag, ".HEX3"}, HEX3, seg_tab[m_card[3]]);
        chk({tag, ".HEX4"}, HEX4, seg_tab[m_card[4]]);
        chk({tag, ".HEX5"}, HEX5, seg_tab[m_card[5]]);
        chk({tag, ".pscore"}, {3'b0, pscore_out}, {3'b0, ps});
        chk({tag, ".dscore"}, {3'b0, dscore_out}, {3'b0, ds});
        chk({tag, ".pcard3"}, {3'b0, pcard3_out}, {3'b0, p3});
        $display("txn %-10s loads=%b cards=%0d,%0d,%0d/%0d,%0d,%0d pscore=%0d dscore=%0d",
                 tag, ld, m_card[0], m_card[1], m_card[2], m_card[3], m_card[4], m_card[5],
                 pscore_out, dscore_out);
    endtask

    // One clock edge with the given strobes, then update model and check.
    task automatic tick(input logic [5:0] loads, input string tag);
        int c;
        ld = loads;
        @(posedge slow_clock);
        c = current_card();
        for (int i = 0; i < 6; i++)
            if (loads[i]) m_card[i] = c;
        edges_since_reset++;
        #1;
        ld = 6'b0;
        check_all(tag);
    endtask

    task automatic model_reset();
        edges_since_reset = 0;
        for (int i = 0; i < 6; i++) m_card[i] = 0;
    endtask

    initial begin
        seg_tab[0]  = 7'b1111111; seg_tab[1]  = 7'b0001000;
        seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
        seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
        seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
        seg_tab[10] = 7'b1000000; seg_tab[11] = 7'b1100001;
        seg_tab[12] = 7'b0011000; seg_tab[13] = 7'b0001001;
        seg_tab[14] = 7'b1111111; seg_tab[15] = 7'b1111111;
        model_reset();

        // Reset held low, with strobes active to show they are ignored.
        ld = 6'b111111;
        #3;
        check_all("reset");
        @(negedge slow_clock);
        check_all("reset_clk");

        // Release reset mid-cycle, first strobe loads Ace into pcard1.
        resetb = 1'b1;
        tick(6'b000001, "p1_ace");
        chk("p1_ace.pscore_const", {3'b0, pscore_out}, 7'd1);

        // pcard2, pcard3, dcard1, dcard2, dcard3 on consecutive edges.
        tick(6'b000010, "p2");
        tick(6'b000100, "p3");
        tick(6'b001000, "d1");
        tick(6'b010000, "d2");
        tick(6'b100000, "d3");
        chk("seq.pcard3_const", {3'b0, pcard3_out}, 7'd3);
        chk("seq.pscore_const", {3'b0, pscore_out}, 7'd6);
        chk("seq.dscore_const", {3'b0, dscore_out}, 7'd5);

        // Idle to counter = 13, then load King.
        for (int i = 0; i < 6; i++) tick(6'b000000, "idle");
        tick(6'b000001, "p1_king");
        chk("king.HEX0_const", HEX0, 7'b0001001);
        chk("king.pscore_const", {3'b0, pscore_out}, 7'd5);

        // Counter wraps to 1; idle to 10 and load two dealer cards at once.
        for (int i = 0; i < 9; i++) tick(6'b000000, "idle2");
        tick(6'b011000, "d1d2_ten");
        chk("ten.HEX3_const", HEX3, 7'b1000000);
        chk("ten.HEX4_const", HEX4, 7'b1000000);
        chk("ten.dscore_const", {3'b0, dscore_out}, 7'd6);

        // Randomized strobe patterns, mostly sparse with occasional bursts.
        for (int i = 0; i < 40; i++) begin
            logic [5:0] r;
            r = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) r = r & 6'($urandom_range(0, 63));
            tick(r, "rand");
        end

        // Asynchronous reset between edges with loads active.
        #2;
        ld = 6'b101101;
        resetb = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(posedge slow_clock);
        #1;
        check_all("rst_hold");

        // Recover and confirm the generator restarted at Ace.
        @(negedge slow_clock);
        resetb = 1'b1;
        tick(6'b111111, "post_all");
        for (int i = 0; i < 20; i++) tick(6'($urandom_range(0, 63)), "rand2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
